// File: rtl/rd_512b_from_bram.sv
// rd_512b_from_bram
// Reads one 512-bit image row out of the frame BRAM as sixteen 32-bit dword
// reads through the BRAM read controller's trig/done handshake, and assembles
// them into one word (dword 0 in [511:480]).
//
// Optional feature macro: RD_TIMEOUT_EN
//   Defined   : a per-dword wait counter aborts a dword after TIMEOUT_CYCLES
//               cycles without done, sets o_timeout and finishes the transfer.
//   Undefined : no counter; REQ waits for done indefinitely, o_timeout = 0.
//
// Ports:
//   i_clk, i_rstn        clock, synchronous active-low reset
//   i_trig / o_done      master handshake; o_done = done_pre & i_trig
//   i_rd_row_num         row 0..511, latched at start
//   o_rd_data_512b       assembled row, updated only on a completed read
//   o_timeout            a dword read timed out (RD_TIMEOUT_EN only)
//   o_rd_from_bram_*     dword read request to the BRAM read controller
//   i_rd_from_bram_*     read data / completion from the controller
module rd_512b_from_bram #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_trig,
    output logic         o_done,
    input  logic [8:0]   i_rd_row_num,
    output logic [511:0] o_rd_data_512b,
    output logic         o_timeout,
    output logic [12:0]  o_rd_from_bram_addr,
    output logic         o_rd_from_bram_trig,
    input  logic [31:0]  i_rd_from_bram_data,
    input  logic         i_rd_from_bram_done
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [8:0]     row_q, row_d;
    logic [511:0]   shadow_q, shadow_d;
    logic [511:0]   data_q, data_d;
    logic [12:0]    addr_q, addr_d;
    logic           trig_q, trig_d;
    logic           done_pre_q, done_pre_d;

    // Only accept done while our request is up; the slave gates it anyway.
    logic rsp;
    logic tmo_hit;
    assign rsp = trig_q & i_rd_from_bram_done;

`ifdef RD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    // cnt_q counts completed waiting cycles; the last allowed one fires here.
    assign tmo_hit = trig_q && !i_rd_from_bram_done && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        if (state_q == S_IDLE && i_trig) begin
            tmo_d = 1'b0;
        end else if (state_q == S_REQ) begin
            if (!trig_q)                   cnt_d = '0;  // dword issue cycle
            else if (!i_rd_from_bram_done) cnt_d = cnt_q + 1'b1;
            if (i_trig && tmo_hit)         tmo_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign o_timeout = tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign tmo_hit    = 1'b0;
    assign o_timeout  = 1'b0;
`endif

    // State register (plus datapath registers)
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            row_q      <= '0;
            shadow_q   <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            trig_q     <= 1'b0;
            done_pre_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            shadow_q   <= shadow_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            trig_q     <= trig_d;
            done_pre_q <= done_pre_d;
        end
    end

    // Next-state logic; a dropped i_trig in REQ wins over done and timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_trig) state_d = S_REQ;
            S_REQ: begin
                if (!i_trig)                      state_d = S_IDLE;
                else if (rsp && idx_q == 4'd15)   state_d = S_DONE;
                else if (!rsp && tmo_hit)         state_d = S_DONE;
            end
            S_DONE: if (!i_trig) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        idx_d      = idx_q;
        row_d      = row_q;
        shadow_d   = shadow_q;
        data_d     = data_q;
        addr_d     = addr_q;
        trig_d     = trig_q;
        done_pre_d = done_pre_q;
        case (state_q)
            S_IDLE: begin
                trig_d     = 1'b0;
                done_pre_d = 1'b0;
                if (i_trig) begin
                    row_d = i_rd_row_num;
                    idx_d = '0;
                end
            end
            S_REQ: begin
                if (!i_trig) begin
                    trig_d = 1'b0;
                end else if (rsp) begin
                    trig_d = 1'b0;
                    for (int k = 0; k < 16; k++)
                        if (idx_q == 4'(k)) shadow_d[511-32*k -: 32] = i_rd_from_bram_data;
                    // Last dword bypasses the shadow so the row lands in one step.
                    if (idx_q == 4'd15) data_d = {shadow_q[511:32], i_rd_from_bram_data};
                    else                idx_d  = idx_q + 4'd1;
                end else if (tmo_hit) begin
                    trig_d = 1'b0;
                end else begin
                    trig_d = 1'b1;
                    addr_d = {row_q, idx_q};
                end
            end
            S_DONE: begin
                trig_d     = 1'b0;
                done_pre_d = i_trig;
            end
            default: begin
                trig_d     = 1'b0;
                done_pre_d = 1'b0;
            end
        endcase
    end

    assign o_done              = done_pre_q & i_trig;
    assign o_rd_data_512b      = data_q;
    assign o_rd_from_bram_addr = addr_q;
    assign o_rd_from_bram_trig = trig_q;

endmodule

// File: tb/tb_rd_512b_from_bram.sv
module tb_rd_512b_from_bram;

`ifdef RD_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic         i_clk;
    logic         i_rstn;
    logic         i_trig;
    logic         o_done;
    logic [8:0]   i_rd_row_num;
    logic [511:0] o_rd_data_512b;
    logic         o_timeout;
    logic [12:0]  o_rd_from_bram_addr;
    logic         o_rd_from_bram_trig;
    logic [31:0]  i_rd_from_bram_data;
    logic         i_rd_from_bram_done;

    rd_512b_from_bram #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk               (i_clk),
        .i_rstn              (i_rstn),
        .i_trig              (i_trig),
        .o_done              (o_done),
        .i_rd_row_num        (i_rd_row_num),
        .o_rd_data_512b      (o_rd_data_512b),
        .o_timeout           (o_timeout),
        .o_rd_from_bram_addr (o_rd_from_bram_addr),
        .o_rd_from_bram_trig (o_rd_from_bram_trig),
        .i_rd_from_bram_data (i_rd_from_bram_data),
        .i_rd_from_bram_done (i_rd_from_bram_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // BRAM read controller model: done after L cycles of trig, gated by trig.
    int          slv_L = 1;
    logic        slv_en = 1'b0;
    logic [31:0] slv_base = '0;
    int          scnt = 0;
    always @(posedge i_clk)
        if (!o_rd_from_bram_trig || i_rd_from_bram_done) scnt <= 0;
        else                                             scnt <= scnt + 1;
    assign i_rd_from_bram_done = o_rd_from_bram_trig && slv_en && (scnt == slv_L - 1);
    assign i_rd_from_bram_data = slv_base + {28'd0, o_rd_from_bram_addr[3:0]};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ndone = 0;
    int hi_run = 0, lo_run = 0, mon_L = 1;
    bit seen_hi = 0, gap_chk = 0;
    logic [12:0]  exp_q[$];
    logic [511:0] prev = '0;

    typedef struct {
        logic [8:0]  row;
        int          L;
        logic [31:0] base;
        int          lat;
        int          chg_after;
        logic [8:0]  chg_row;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // One clock; sample after the falling edge, then run the address scoreboard
    // and the trig shape tracker.
    task automatic tick();
        @(negedge i_clk);
        #1;
        cyc++;
        if (o_rd_from_bram_trig) begin
            if (seen_hi && lo_run > 0 && gap_chk) chk("trig_gap", lo_run, 1);
            lo_run = 0;
            hi_run++;
            seen_hi = 1;
        end else begin
            if (seen_hi) lo_run++;
            hi_run = 0;
        end
        if (o_rd_from_bram_trig && i_rd_from_bram_done) begin
            ndone++;
            if (exp_q.size() == 0) chk("addr_unexpected", 1, 0);
            else chk("addr", o_rd_from_bram_addr, exp_q.pop_front());
            if (gap_chk) chk("dword_len", hi_run, mon_L);
        end
    endtask

    task automatic setup_xfer(input logic [8:0] row, input int L, input logic [31:0] base,
                              output logic [511:0] expv);
        slv_L = L; mon_L = L; slv_base = base; slv_en = 1'b1;
        gap_chk = 1; seen_hi = 0; lo_run = 0; hi_run = 0;
        expv = '0;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back({row, 4'(k)});
            expv = {expv[479:0], base + 32'(k)};
        end
        i_rd_row_num = row;
        i_trig = 1'b1;
    endtask

    task automatic do_read(input vec_t v);
        logic [511:0] expv;
        int n0, start;
        setup_xfer(v.row, v.L, v.base, expv);
        n0 = ndone;
        tick();
        start = cyc;
        for (int i = 0; i < 2000 && !o_done; i++) begin
            if (v.chg_after >= 0 && ndone - n0 >= v.chg_after) i_rd_row_num = v.chg_row;
            tick();
        end
        chk("done_seen", o_done, 1);
        chk("latency", cyc - start, v.lat);
        chk("data", o_rd_data_512b, expv);
        chk("dwords_left", exp_q.size(), 0);
        chk("timeout_clr", o_timeout, 0);
        chk("trig_idle", o_rd_from_bram_trig, 0);
        i_trig = 1'b0;
        #1;
        chk("done_comb_fall", o_done, 0);
        tick(); tick();
        chk("data_hold", o_rd_data_512b, expv);
        prev = expv;
        exp_q.delete();
    endtask

    // Drop i_trig after 'after' dwords; same_cyc drops it while the last one's
    // done is still up so the abort collides with the response.
    task automatic do_abort(input int after, input bit same_cyc);
        logic [511:0] expv;
        int n0;
        bit saw_done;
        setup_xfer(9'd7, 1, 32'hDEAD_0000, expv);
        n0 = ndone;
        saw_done = 0;
        for (int i = 0; i < 200 && (ndone - n0) < after; i++) begin
            tick();
            if (o_done) saw_done = 1;
        end
        chk("abort_reach", ndone - n0, after);
        if (!same_cyc) tick();
        i_trig = 1'b0;
        tick();
        chk("abort_trig", o_rd_from_bram_trig, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_done || o_rd_from_bram_trig) saw_done = 1;
        end
        chk("abort_quiet", saw_done, 0);
        chk("abort_data", o_rd_data_512b, prev);
        chk("abort_no_more", ndone - n0, after);
        exp_q.delete();
    endtask

    initial begin
        int n0, n;
        bit bad;
        logic [511:0] dummy;
        tbl[0] = '{9'd5,   1, 32'hA500_0000, 33, -1, 9'd0};
        tbl[1] = '{9'd511, 3, 32'h3C00_0000, 65, -1, 9'd0};
        tbl[2] = '{9'd0,   2, 32'h1234_5600, 49, -1, 9'd0};
        tbl[3] = '{9'd5,   1, 32'h5A00_0000, 33,  4, 9'd9};
        tbl[4] = '{9'd256, 1, 32'hFFFF_FFF0, 33, -1, 9'd0};

        i_rstn = 1'b0; i_trig = 1'b0; i_rd_row_num = '0;
        tick(); tick(); tick();
        chk("rst_data", o_rd_data_512b, 0);
        chk("rst_addr", o_rd_from_bram_addr, 0);
        chk("rst_trig", o_rd_from_bram_trig, 0);
        chk("rst_done", o_done, 0);
        chk("rst_timeout", o_timeout, 0);
        i_rstn = 1'b1;
        tick();

        foreach (tbl[i]) do_read(tbl[i]);

        do_abort(8, 1'b0);
        do_abort(8, 1'b1);
        tick(); tick();

        // Reset in the middle of a transfer, i_trig still high.
        setup_xfer(9'd3, 2, 32'h0BAD_0000, dummy);
        n0 = ndone;
        for (int i = 0; i < 200 && (ndone - n0) < 3; i++) tick();
        i_rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_data", o_rd_data_512b, 0);
            chk("mid_rst_addr", o_rd_from_bram_addr, 0);
            chk("mid_rst_trig", o_rd_from_bram_trig, 0);
            chk("mid_rst_done", o_done, 0);
        end
        i_trig = 1'b0;
        i_rstn = 1'b1;
        tick(); tick();
        chk("post_rst_trig", o_rd_from_bram_trig, 0);
        chk("post_rst_done", o_done, 0);
        exp_q.delete();
        prev = '0;

        // Unresponsive slave.
        slv_en = 1'b0; gap_chk = 0; seen_hi = 0;
        i_rd_row_num = 9'd20;
        i_trig = 1'b1;
`ifdef RD_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (o_rd_from_bram_trig) n++;
            else if (n > 0) break;
        end
        chk("tmo_trig_len", n, TMO);
        tick();
        chk("tmo_flag", o_timeout, 1);
        chk("tmo_done", o_done, 1);
        chk("tmo_data", o_rd_data_512b, prev);
        i_trig = 1'b0;
        tick(); tick();
        chk("tmo_sticky", o_timeout, 1);
        chk("tmo_done_fall", o_done, 0);
        do_read(tbl[0]);
`else
        tick(); tick();
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (!o_rd_from_bram_trig || o_timeout || o_done) bad = 1;
        end
        chk("no_tmo_hold", bad, 0);
        chk("no_tmo_flag", o_timeout, 0);
        i_trig = 1'b0;
        tick(); tick();
        chk("no_tmo_abort", o_rd_from_bram_trig, 0);
        do_read(tbl[0]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
